// File: rtl/noc_pkg.sv
// noc_pkg: shared flit types, port indices and input-state encoding for the wormhole router
package noc_pkg;
  localparam int NUM_PORTS = 5;
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ROUTED, ST_DROP} in_state_t;
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: synchronous flit FIFO with occupancy count; read and write may coincide
module noc_flit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_wr, do_rd;
  assign full = int'(count) == FIFO_DEPTH;
  assign empty = count == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) if (do_wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      count  <= count + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/noc_wormhole_router.sv
// noc_wormhole_router: 5-port XY wormhole mesh router, per-input FIFOs, per-output round-robin locks
module noc_wormhole_router
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int X_COORD     = 0,
  parameter int Y_COORD     = 0,
  parameter int MESH_SIZE_X = 4,
  parameter int MESH_SIZE_Y = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic                            err_route
);
  localparam int XW = MESH_SIZE_X > 2 ? $clog2(MESH_SIZE_X) : 1;
  localparam int YW = MESH_SIZE_Y > 2 ? $clog2(MESH_SIZE_Y) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] head [NUM_PORTS];
  logic [CW-1:0] count [NUM_PORTS];
  logic [2:0] route [NUM_PORTS];
  logic [2:0] sel [NUM_PORTS], sel_nx [NUM_PORTS];
  logic [2:0] ptr [NUM_PORTS], ptr_nx [NUM_PORTS];
  logic [2:0] src [NUM_PORTS];
  in_state_t state [NUM_PORTS], state_nx [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty, pop, err, load, held, bad, is_head, is_tail;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [1:0] ft;
    noc_flit_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid[p] && in_ready[p]),
      .wr_data (in_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en   (pop[p]),
      .rd_data (head[p]),
      .count   (count[p]),
      .empty   (empty[p])
    );
    assign ft = head[p][DATA_WIDTH-1 -: 2];
    assign dx = head[p][DATA_WIDTH-3 -: XW];
    assign dy = head[p][DATA_WIDTH-3-XW -: YW];
    assign in_ready[p] = int'(count[p]) != FIFO_DEPTH;
    assign is_head[p] = ft == FLIT_HEAD || ft == FLIT_SINGLE;
    assign is_tail[p] = ft == FLIT_TAIL || ft == FLIT_SINGLE;
    assign route[p] = int'(dx) > X_COORD ? PORT_EAST :
                      int'(dx) < X_COORD ? PORT_WEST :
                      int'(dy) > Y_COORD ? PORT_NORTH :
                      int'(dy) < Y_COORD ? PORT_SOUTH : PORT_LOCAL;
    // Sending a packet back out of the port it arrived on is a routing error, except for the PE.
    assign bad[p] = int'(dx) >= MESH_SIZE_X || int'(dy) >= MESH_SIZE_Y ||
                    (p != 0 && route[p] == 3'(p));
  end
  always_comb begin : b_alloc
    logic found;
    int idx;
    found = 1'b0;
    idx = 0;
    pop = '0;
    err = '0;
    load = '0;
    held = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      src[i] = '0;
      ptr_nx[i] = ptr[i];
      state_nx[i] = state[i];
      sel_nx[i] = sel[i];
    end
    for (int i = 0; i < NUM_PORTS; i++)
      if (state[i] == ST_ROUTED) begin
        held[sel[i]] = 1'b1;
        src[sel[i]] = 3'(i);
      end
    for (int o = 0; o < NUM_PORTS; o++) begin
      found = held[o];
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = (int'(ptr[o]) + i) % NUM_PORTS;
        if (!found && state[idx] == ST_IDLE && !empty[idx] && is_head[idx] && !bad[idx] &&
            route[idx] == 3'(o)) begin
          found = 1'b1;
          src[o] = 3'(idx);
        end
      end
      load[o] = found && !empty[src[o]] && (!out_valid[o] || out_ready[o]);
      if (load[o]) pop[src[o]] = 1'b1;
      if (load[o] && !held[o]) ptr_nx[o] = 3'((int'(src[o]) + 1) % NUM_PORTS);
    end
    // The lock is taken only when the head actually moves, so a stalled output never idles a grant.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (state[i] == ST_IDLE && !empty[i] && (!is_head[i] || bad[i])) begin
        pop[i] = 1'b1;
        err[i] = 1'b1;
        state_nx[i] = is_head[i] && !is_tail[i] ? ST_DROP : ST_IDLE;
      end else if (state[i] == ST_DROP && !empty[i]) begin
        pop[i] = 1'b1;
        state_nx[i] = is_tail[i] ? ST_IDLE : ST_DROP;
      end else if (pop[i] && state[i] == ST_IDLE && !is_tail[i]) begin
        state_nx[i] = ST_ROUTED;
        sel_nx[i] = route[i];
      end else if (pop[i] && state[i] == ST_ROUTED && is_tail[i]) begin
        state_nx[i] = ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      state[i] <= rst ? ST_IDLE : state_nx[i];
      sel[i]   <= rst ? '0 : sel_nx[i];
      ptr[i]   <= rst ? '0 : ptr_nx[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      err_route <= 1'b0;
    end else begin
      err_route <= |err;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (load[o]) begin
          out_valid[o] <= 1'b1;
          out_data[o*DATA_WIDTH +: DATA_WIDTH] <= head[src[o]];
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_wormhole_router.sv
// tb_noc_wormhole_router: directed checks of the router at tile (1,1) in a 4x4 mesh
module tb_noc_wormhole_router;
  localparam int DW = 32;
  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SINGLE = 2'b11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5*DW-1:0] in_data = '0;
  logic [5*DW-1:0] out_data;
  logic [4:0] in_valid = '0;
  logic [4:0] out_ready = 5'h1f;
  logic [4:0] in_ready, out_valid;
  logic err_route;
  int n_cmp = 0, n_bad = 0, errs = 0;
  logic [34:0] cap [$];
  logic [31:0] txd [5][8];
  int txn [5], txi [5];
  always #5 clk = ~clk;
  noc_wormhole_router #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(4), .X_COORD(1), .Y_COORD(1), .MESH_SIZE_X(4), .MESH_SIZE_Y(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err_route(err_route)
  );
  always @(posedge clk) begin
    if (err_route === 1'b1) errs++;
    for (int o = 0; o < 5; o++)
      if (out_valid[o] === 1'b1 && out_ready[o]) cap.push_back({3'(o), out_data[o*DW +: DW]});
  end
  function automatic logic [31:0] mk(logic [1:0] t, int dx, int dy, int pay);
    return {t, 2'(dx), 2'(dy), 26'(pay)};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(string tag, int p, logic [31:0] exp);
    chk(tag, 64'({out_valid[p], out_data[p*DW +: DW]}), 64'({1'b1, exp}));
  endtask
  task automatic chk_cap(string tag, int k, int port, logic [31:0] exp);
    logic [34:0] v;
    v = k < cap.size() ? cap[k] : 'x;
    chk($sformatf("%s%0d", tag, k), 64'(v), 64'({3'(port), exp}));
  endtask
  task automatic clr_tx();
    for (int p = 0; p < 5; p++) begin
      txn[p] = 0;
      txi[p] = 0;
    end
  endtask
  task automatic tx(int p, logic [31:0] f);
    txd[p][txn[p]] = f;
    txn[p]++;
  endtask
  task automatic run_tx(int n);
    logic [4:0] fire;
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 5; p++) begin
        in_valid[p] = txi[p] < txn[p];
        in_data[p*DW +: DW] = in_valid[p] ? txd[p][txi[p]] : '0;
      end
      fire = in_valid & in_ready;
      cyc();
      for (int p = 0; p < 5; p++) if (fire[p]) txi[p]++;
    end
    in_valid = '0;
  endtask
  initial begin
    logic [31:0] f [6];
    clr_tx();
    cyc();
    cyc();
    chk("rst_in_ready", 64'(in_ready), 64'(5'h1f));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_err", 64'(err_route), 64'(0));
    rst = 1'b0;
    // local SINGLE to own tile: two-cycle latency to the local output
    f[0] = mk(SINGLE, 1, 1, 'h3a5a5a5);
    in_valid[0] = 1'b1;
    in_data[0 +: DW] = f[0];
    cyc();
    in_valid = '0;
    chk("t1_not_yet", 64'(out_valid), 64'(0));
    cyc();
    chk_out("t1_local", 0, f[0]);
    chk("t1_only_local", 64'(out_valid), 64'(5'b00001));
    chk("t1_err", 64'(err_route), 64'(0));
    cyc();
    chk("t1_gone", 64'(out_valid), 64'(0));
    // west packet to (3,2) streams east back-to-back
    f[0] = mk(HEAD, 3, 2, 'h100);
    f[1] = mk(BODY, 0, 0, 'h101);
    f[2] = mk(BODY, 3, 3, 'h102);
    f[3] = mk(TAIL, 0, 0, 'h103);
    in_valid[4] = 1'b1;
    in_data[4*DW +: DW] = f[0];
    cyc();
    for (int k = 1; k < 4; k++) begin
      in_data[4*DW +: DW] = f[k];
      cyc();
      chk_out($sformatf("t2_east%0d", k - 1), 2, f[k-1]);
    end
    in_valid = '0;
    cyc();
    chk_out("t2_east3", 2, f[3]);
    cyc();
    chk("t2_idle", 64'(out_valid), 64'(0));
    // north vs south contention for east; north queues a second packet behind its first
    cap.delete();
    clr_tx();
    tx(1, mk(HEAD, 2, 1, 'h11)); tx(1, mk(BODY, 0, 0, 'h12)); tx(1, mk(TAIL, 0, 0, 'h13));
    tx(1, mk(HEAD, 2, 1, 'h21)); tx(1, mk(BODY, 0, 0, 'h22)); tx(1, mk(TAIL, 0, 0, 'h23));
    tx(3, mk(HEAD, 2, 1, 'h31)); tx(3, mk(BODY, 0, 0, 'h32)); tx(3, mk(TAIL, 0, 0, 'h33));
    run_tx(20);
    chk("t3_count", 64'(cap.size()), 64'(9));
    for (int k = 0; k < 3; k++) chk_cap("t3_n1_", k, 2, txd[1][k]);
    for (int k = 0; k < 3; k++) chk_cap("t3_s1_", k + 3, 2, txd[3][k]);
    for (int k = 0; k < 3; k++) chk_cap("t3_n2_", k + 6, 2, txd[1][k+3]);
    // east backpressure: FIFO plus output register absorb five flits
    cap.delete();
    clr_tx();
    out_ready[2] = 1'b0;
    tx(0, mk(HEAD, 2, 1, 'h40));
    for (int k = 1; k < 5; k++) tx(0, mk(BODY, 0, 0, 'h40 + k));
    tx(0, mk(TAIL, 0, 0, 'h45));
    run_tx(8);
    chk("t4_accepted", 64'(txi[0]), 64'(5));
    chk("t4_in_ready", 64'(in_ready[0]), 64'(0));
    chk_out("t4_held", 2, txd[0][0]);
    run_tx(2);
    chk_out("t4_still_held", 2, txd[0][0]);
    out_ready = 5'h1f;
    run_tx(12);
    chk("t4_all_sent", 64'(txi[0]), 64'(6));
    chk("t4_count", 64'(cap.size()), 64'(6));
    for (int k = 0; k < 6; k++) chk_cap("t4_", k, 2, txd[0][k]);
    // misrouted packet (east input to east output) dropped with one error pulse
    cap.delete();
    clr_tx();
    errs = 0;
    tx(2, mk(HEAD, 3, 0, 'h50)); tx(2, mk(BODY, 0, 0, 'h51)); tx(2, mk(TAIL, 0, 0, 'h52));
    tx(2, mk(SINGLE, 1, 1, 'h53));
    run_tx(12);
    chk("t5_err_pulses", 64'(errs), 64'(1));
    chk("t5_count", 64'(cap.size()), 64'(1));
    chk_cap("t5_next_", 0, 0, txd[2][3]);
    clr_tx();
    errs = 0;
    tx(0, mk(BODY, 0, 0, 'h60));
    run_tx(5);
    chk("t5_body_err", 64'(errs), 64'(1));
    chk("t5_body_dropped", 64'(cap.size()), 64'(1));
    // reset in the middle of a packet
    clr_tx();
    out_ready[2] = 1'b0;
    tx(0, mk(HEAD, 2, 1, 'h70)); tx(0, mk(BODY, 0, 0, 'h71));
    run_tx(4);
    chk("t6_pending", 64'(out_valid), 64'(5'b00100));
    rst = 1'b1;
    cyc();
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_in_ready", 64'(in_ready), 64'(5'h1f));
    rst = 1'b0;
    out_ready = 5'h1f;
    cap.delete();
    clr_tx();
    tx(4, mk(HEAD, 3, 1, 'h80)); tx(4, mk(TAIL, 0, 0, 'h81));
    run_tx(8);
    chk("t6_count", 64'(cap.size()), 64'(2));
    for (int k = 0; k < 2; k++) chk_cap("t6_", k, 2, txd[4][k]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
